// File: rtl/quantum_scheduler_pkg.sv
// Shared definitions for the preemptive quantum scheduler: state encoding,
// reset defaults and the I/O-space addresses the OS uses to reach the block.
package quantum_scheduler_pkg;

   localparam int unsigned QS_QW            = 16;
   localparam int unsigned QS_PCW           = 32;
   localparam int unsigned QS_SWC_W         = 8;
   localparam int unsigned QS_DEFAULT_QUANT = 100;
   localparam logic [31:0] QS_HANDLER_ADDR  = 32'd0;

   // I/O-space map: savedPC and switchCount are read-only, cfgQuantum is write-only
   localparam logic [31:0] QS_IO_SAVED_PC_ADDR     = 32'h0000_FF00;
   localparam logic [31:0] QS_IO_SWITCH_COUNT_ADDR = 32'h0000_FF04;
   localparam logic [31:0] QS_IO_CFG_QUANTUM_ADDR  = 32'h0000_FF08;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_REQUEST = 2'd2,
      ST_KERNEL  = 2'd3
   } sched_state_e;

endpackage

// File: rtl/quantum_scheduler_counter.sv
// Loadable down-counter for the remaining slice length, with clear and zero flag.
module quantum_counter
   import quantum_scheduler_pkg::*;
#(
   parameter int unsigned QW = QS_QW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          load,
   input  logic [QW-1:0] load_value,
   input  logic          dec_en,
   output logic [QW-1:0] count,
   output logic          zero_c
);

   logic [QW-1:0] count_d;
   logic [QW-1:0] count_q;

   // clear beats load beats decrement
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_value;
      end else if (dec_en) begin
         count_d = count_q - QW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count  = count_q;
   assign zero_c = (count_q == '0);

endmodule

// File: rtl/quantum_scheduler.sv
// Preemptive time-slice controller: counts retired instructions against a quantum
// and, at expiry, redirects the CPU to the kernel handler at the next boundary.
module quantum_scheduler
   import quantum_scheduler_pkg::*;
#(
   parameter int unsigned     QW            = QS_QW,
   parameter int unsigned     PCW           = QS_PCW,
   parameter logic [QW-1:0]   DEFAULT_QUANT = QW'(QS_DEFAULT_QUANT),
   parameter logic [PCW-1:0]  HANDLER_ADDR  = PCW'(QS_HANDLER_ADDR)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                instrRetire,
   input  logic                halt,
   input  logic                timerEnable,
   input  logic                cfgWrite,
   input  logic [QW-1:0]       cfgQuantum,
   input  logic [PCW-1:0]      pcAtual,
   input  logic                swapAck,
   output logic                irqPending,
   output logic                pcForce,
   output logic [PCW-1:0]      pcForceValue,
   output logic [PCW-1:0]      savedPC,
   output logic                inKernel,
   output logic [QW-1:0]       counter,
   output logic [QS_SWC_W-1:0] switchCount
);

   sched_state_e          state_d, state_q;
   logic [QW-1:0]         quantum_d, quantum_q;
   logic [PCW-1:0]        saved_pc_d, saved_pc_q;
   logic [QS_SWC_W-1:0]   switch_count_d, switch_count_q;
   logic                  pc_force_d, pc_force_q;

   logic                  retire_ok;
   logic                  cfg_ok;
   logic                  cnt_clear;
   logic                  cnt_load;
   logic                  cnt_dec;
   logic [QW-1:0]         cnt_value;
   logic                  cnt_zero;

   assign retire_ok = instrRetire && !halt;
   assign cfg_ok    = cfgWrite && (cfgQuantum != '0);

   // A reload in the same cycle as a config write picks up the new quantum
   assign quantum_d = cfg_ok ? cfgQuantum : quantum_q;

   quantum_counter #(
      .QW(QW)
   ) u_counter (
      .clk       (clock),
      .rst       (reset),
      .clear     (cnt_clear),
      .load      (cnt_load),
      .load_value(quantum_d),
      .dec_en    (cnt_dec),
      .count     (cnt_value),
      .zero_c    (cnt_zero)
   );

   always_comb begin
      state_d        = state_q;
      saved_pc_d     = saved_pc_q;
      switch_count_d = switch_count_q;
      pc_force_d     = 1'b0;
      cnt_clear      = 1'b0;
      cnt_load       = 1'b0;
      cnt_dec        = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (timerEnable) begin
               state_d  = ST_RUN;
               cnt_load = 1'b1;
            end else begin
               cnt_clear = 1'b1;
            end
         end

         ST_RUN: begin
            if (!timerEnable) begin
               state_d   = ST_IDLE;
               cnt_clear = 1'b1;
            end else if (retire_ok && !cnt_zero) begin
               cnt_dec = 1'b1;
               if (cnt_value == QW'(1)) begin
                  state_d = ST_REQUEST;
               end
            end
         end

         // Wait for the next instruction boundary, then capture the resume point
         ST_REQUEST: begin
            if (!timerEnable) begin
               state_d = ST_IDLE;
            end else if (retire_ok) begin
               state_d        = ST_KERNEL;
               saved_pc_d     = pcAtual;
               pc_force_d     = 1'b1;
               switch_count_d = switch_count_q + QS_SWC_W'(1);
            end
         end

         ST_KERNEL: begin
            if (swapAck) begin
               if (timerEnable) begin
                  state_d  = ST_RUN;
                  cnt_load = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d   = ST_IDLE;
            cnt_clear = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         quantum_q      <= DEFAULT_QUANT;
         saved_pc_q     <= '0;
         switch_count_q <= '0;
         pc_force_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         quantum_q      <= quantum_d;
         saved_pc_q     <= saved_pc_d;
         switch_count_q <= switch_count_d;
         pc_force_q     <= pc_force_d;
      end
   end

   assign irqPending   = (state_q == ST_REQUEST);
   assign inKernel     = (state_q == ST_KERNEL);
   assign pcForce      = pc_force_q;
   assign pcForceValue = HANDLER_ADDR;
   assign savedPC      = saved_pc_q;
   assign switchCount  = switch_count_q;
   assign counter      = cnt_value;

endmodule
